// File: rtl/fifo_wr_pkg.sv
// rtl/fifo_wr_pkg.sv - state encoding and shared defaults for the FIFO test controllers
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Default pattern width, shared with the read-side controller.
    localparam int DATA_W_DEF = 8;

    // Settle counter width; covers the full 1..255 settle range.
    localparam int DLY_W = 8;

endpackage

// File: rtl/fifo_wr_sync_2ff.sv
// rtl/fifo_wr_sync_2ff.sv - two-flop synchronizer for a single-bit flag, reset value 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/fifo_wr.sv
// rtl/fifo_wr.sv - write-side burst controller: wait for empty, settle, burst until almost_full
module fifo_wr
    import fifo_wr_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 10,
    parameter int DATA_INIT  = 0
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              wr_rst_busy,
    input  logic              empty,
    input  logic              almost_full,
    input  logic              full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic [15:0]       burst_cnt,
    output logic              ovf_err
);

    localparam logic [DLY_W-1:0]  DLY_LAST   = DLY_W'(SETTLE_CYC - 1);
    localparam logic [DATA_W-1:0] DATA_FIRST = DATA_W'(DATA_INIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DLY_W-1:0]  r_dly;
    logic [DLY_W-1:0]  w_dly_nxt;
    logic              r_wr_en;
    logic              w_wr_en_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [15:0]       r_burst;
    logic [15:0]       w_burst_nxt;
    logic              r_ovf;
    logic              w_empty_s;

    sync_2ff u_sync_empty (
        .clk   (wr_clk),
        .rst_n (rst_n),
        .i_d   (empty),
        .o_q   (w_empty_s)
    );

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dly   <= '0;
            r_wr_en <= 1'b0;
            r_data  <= DATA_FIRST;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_data  <= w_data_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_wr_en_nxt = r_wr_en;
        w_data_nxt  = r_data;
        w_burst_nxt = r_burst;
        // FIFO reset aborts any burst but keeps pattern and burst history intact.
        if (wr_rst_busy) begin
            w_state_nxt = ST_IDLE;
            w_wr_en_nxt = 1'b0;
            w_dly_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_wr_en_nxt = 1'b0;
                    if (w_empty_s) begin
                        w_dly_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (r_dly == DLY_LAST) begin
                        w_wr_en_nxt = 1'b1;
                        w_data_nxt  = DATA_FIRST;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_dly_nxt = r_dly + 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The write on an almost_full edge still lands in the last free slot.
                    w_data_nxt = r_data + 1'b1;
                    if (almost_full) begin
                        w_wr_en_nxt = 1'b0;
                        w_burst_nxt = r_burst + 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_wr_en_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_wr_en && full) begin
            r_ovf <= 1'b1;
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_data;
    assign burst_cnt    = r_burst;
    assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_fifo_wr.sv
// tb/tb_fifo_wr.sv - self-checking bench for fifo_wr: vector table, directed corners, random ping-pong
module tb_fifo_wr;

    localparam int DATA_W = 8;
    localparam int SETTLE = 10;
    localparam int DEPTH  = 256;
    localparam int AF_LVL = 255;

    logic              wr_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_rst_busy = 1'b0;
    logic              empty = 1'b1;
    logic              almost_full = 1'b0;
    logic              full = 1'b0;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [15:0]       burst_cnt;
    logic              ovf_err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int   n;
        logic e;
        logic af;
        logic f;
        logic b;
        logic en;
        int   data;
        int   burst;
        logic ovf;
    } vec_t;

    vec_t vt[$];

    fifo_wr #(
        .DATA_W     (DATA_W),
        .SETTLE_CYC (SETTLE),
        .DATA_INIT  (0)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .wr_rst_busy  (wr_rst_busy),
        .empty        (empty),
        .almost_full  (almost_full),
        .full         (full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .burst_cnt    (burst_cnt),
        .ovf_err      (ovf_err)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge wr_clk);
    endtask

    // Random-phase reference state: FIFO occupancy and expected burst bookkeeping.
    int   cnt, edge_no, rise_edge, exp_idx, exp_burst;
    logic drain, exp_ovf, p_en, p_af, p_full;
    int   p_data;

    initial begin
        // Columns: edges, empty, almost_full, full, busy | en, data, burst, ovf
        vt.push_back('{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
        vt.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0});
        vt.push_back('{ 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0});
        vt.push_back('{ 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0});
        vt.push_back('{ 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0});
        vt.push_back('{ 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0});
        vt.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0});
        vt.push_back('{ 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0});
        vt.push_back('{ 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0});
        vt.push_back('{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0});
        vt.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0});
        vt.push_back('{ 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1'b1});
        vt.push_back('{ 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b1});
        vt.push_back('{ 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1});
        vt.push_back('{ 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1});

        wait_edges(3);
        chk("rst_en", fifo_wr_en, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_burst", burst_cnt, 0);
        chk("rst_ovf", ovf_err, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            empty       = vt[i].e;
            almost_full = vt[i].af;
            full        = vt[i].f;
            wr_rst_busy = vt[i].b;
            wait_edges(vt[i].n);
            chk($sformatf("vec%0d_en", i), fifo_wr_en, vt[i].en);
            if (vt[i].en) chk($sformatf("vec%0d_data", i), fifo_wr_data, vt[i].data);
            chk($sformatf("vec%0d_burst", i), burst_cnt, vt[i].burst);
            chk($sformatf("vec%0d_ovf", i), ovf_err, vt[i].ovf);
        end

        // wr_rst_busy pulse in the middle of a burst.
        empty = 1'b1;
        wait_edges(13);
        chk("busy_pre_en", fifo_wr_en, 1);
        wait_edges(3);
        chk("busy_pre_data", fifo_wr_data, 3);
        wr_rst_busy = 1'b1;
        wait_edges(1);
        chk("busy_en", fifo_wr_en, 0);
        chk("busy_data_hold", fifo_wr_data, 3);
        chk("busy_burst_hold", burst_cnt, 3);
        for (int k = 0; k < 4; k++) begin
            wait_edges(1);
            chk($sformatf("busy_block%0d", k), fifo_wr_en, 0);
        end
        wr_rst_busy = 1'b0;
        wait_edges(10);
        chk("busy_rel_wait", fifo_wr_en, 0);
        wait_edges(1);
        chk("busy_rel_en", fifo_wr_en, 1);
        chk("busy_rel_data", fifo_wr_data, 0);
        chk("busy_rel_burst", burst_cnt, 3);
        chk("ovf_sticky", ovf_err, 1);
        empty = 1'b0;
        almost_full = 1'b1;
        wait_edges(1);
        chk("busy_end_en", fifo_wr_en, 0);
        chk("busy_end_burst", burst_cnt, 4);
        chk("ovf_sticky_end", ovf_err, 1);
        almost_full = 1'b0;

        rst_n = 1'b0;
        wait_edges(1);
        chk("rst2_ovf", ovf_err, 0);
        chk("rst2_burst", burst_cnt, 0);
        chk("rst2_en", fifo_wr_en, 0);

        // Random ping-pong against a depth-256 FIFO model with a randomly paced drain.
        empty = 1'b1;
        almost_full = 1'b0;
        full = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
        cnt = 0; drain = 1'b0; edge_no = 0; rise_edge = 0;
        exp_idx = 0; exp_burst = 0; exp_ovf = 1'b0;
        p_en = 1'b0; p_data = 0; p_af = 1'b0; p_full = 1'b0;
        while (exp_burst < 3 && edge_no < 20000) begin
            @(negedge wr_clk);
            edge_no++;
            if (p_en) begin
                chk("rnd_data", p_data, exp_idx % 256);
                exp_idx++;
                cnt++;
                if (p_full) exp_ovf = 1'b1;
                if (p_af) begin
                    exp_burst++;
                    chk("rnd_burst_len", exp_idx, DEPTH);
                    exp_idx = 0;
                    chk("rnd_end_en", fifo_wr_en, 0);
                    chk("rnd_burst_cnt", burst_cnt, exp_burst);
                    chk("rnd_ovf", ovf_err, exp_ovf);
                end else begin
                    chk("rnd_en_hold", fifo_wr_en, 1);
                end
            end else if (fifo_wr_en) begin
                chk("rnd_start_edge", edge_no, rise_edge + SETTLE + 3);
            end
            if (cnt >= DEPTH) drain = 1'b1;
            if (drain && cnt > 0 && ($urandom_range(0, 1) == 1)) begin
                cnt--;
                if (cnt == 0) begin
                    drain = 1'b0;
                    rise_edge = edge_no;
                end
            end
            empty       = (cnt == 0);
            almost_full = (cnt >= AF_LVL);
            full        = (cnt >= DEPTH);
            p_en   = fifo_wr_en;
            p_data = int'(fifo_wr_data);
            p_af   = almost_full;
            p_full = full;
        end
        chk("rnd_done", exp_burst, 3);
        chk("rnd_final_burst", burst_cnt, 3);
        chk("rnd_final_ovf", ovf_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
